// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush and hold; PERF_CNT_EN adds bubble/flush counters.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  hold_i,
    input  logic [1:0]            alu_op_i,
    input  logic [1:0]            reg_dst_i,
    input  logic [1:0]            mem_to_reg_i,
    input  logic [1:0]            branch_i,
    input  logic                  alu_src_i,
    input  logic                  reg_write_i,
    input  logic                  jump_i,
    input  logic                  mem_read_i,
    input  logic                  mem_write_i,
    input  logic [DATA_W-1:0]     pc_plus4_i,
    input  logic [DATA_W-1:0]     rs_data_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [DATA_W-1:0]     imm_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic [1:0]            alu_op_o,
    output logic [1:0]            reg_dst_o,
    output logic [1:0]            mem_to_reg_o,
    output logic [1:0]            branch_o,
    output logic                  alu_src_o,
    output logic                  reg_write_o,
    output logic                  jump_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [DATA_W-1:0]     pc_plus4_o,
    output logic [DATA_W-1:0]     rs_data_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic                  valid_o,
    output logic                  stall_o,
    output logic [31:0]           bubble_cnt_o,
    output logic [31:0]           flush_cnt_o
);
    logic lu, bubble;
    assign lu      = valid_o & mem_read_o & (rt_o != '0) & ((rt_o == rs_i) | (rt_o == rt_i));
    assign stall_o = (lu | hold_i) & ~flush_i;
    assign bubble  = flush_i | lu;
    // flush overrides hold; a bubble zeroes controls but still carries the datapath fields
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_op_o     <= '0;
            reg_dst_o    <= '0;
            mem_to_reg_o <= '0;
            branch_o     <= '0;
            alu_src_o    <= 1'b0;
            reg_write_o  <= 1'b0;
            jump_o       <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            pc_plus4_o   <= '0;
            rs_data_o    <= '0;
            rt_data_o    <= '0;
            imm_o        <= '0;
            rs_o         <= '0;
            rt_o         <= '0;
            rd_o         <= '0;
            valid_o      <= 1'b0;
        end else if (flush_i | ~hold_i) begin
            alu_op_o     <= bubble ? '0 : alu_op_i;
            reg_dst_o    <= bubble ? '0 : reg_dst_i;
            mem_to_reg_o <= bubble ? '0 : mem_to_reg_i;
            branch_o     <= bubble ? '0 : branch_i;
            alu_src_o    <= ~bubble & alu_src_i;
            reg_write_o  <= ~bubble & reg_write_i;
            jump_o       <= ~bubble & jump_i;
            mem_read_o   <= ~bubble & mem_read_i;
            mem_write_o  <= ~bubble & mem_write_i;
            pc_plus4_o   <= pc_plus4_i;
            rs_data_o    <= rs_data_i;
            rt_data_o    <= rt_data_i;
            imm_o        <= imm_i;
            rs_o         <= rs_i;
            rt_o         <= rt_i;
            rd_o         <= rd_i;
            valid_o      <= ~bubble;
        end
    end
`ifdef PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt_o <= '0;
            flush_cnt_o  <= '0;
        end else begin
            if (flush_i && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 32'd1;
            if (~flush_i && ~hold_i && lu && bubble_cnt_o != '1)
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`else
    assign bubble_cnt_o = '0;
    assign flush_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random stimulus for id_ex_stage, checked every cycle against a rule-level model.
module tb_id_ex_stage;
    typedef struct packed {
        logic [1:0]  alu_op, reg_dst, mem_to_reg, branch;
        logic        alu_src, reg_write, jump, mem_read, mem_write;
        logic [31:0] pc_plus4, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic        valid;
    } ex_t;

`ifdef PERF_CNT_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, hold_i = 1'b0;
    ex_t  in = '0;
    ex_t  m = '0, dut_v, b, l;
    logic [31:0] mbc = 0, mfc = 0;
    logic started = 1'b0;
    int checks = 0, errors = 0;

    logic [1:0]  alu_op_o, reg_dst_o, mem_to_reg_o, branch_o;
    logic        alu_src_o, reg_write_o, jump_o, mem_read_o, mem_write_o, valid_o, stall_o;
    logic [31:0] pc_plus4_o, rs_data_o, rt_data_o, imm_o, bubble_cnt_o, flush_cnt_o;
    logic [4:0]  rs_o, rt_o, rd_o;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i),
        .alu_op_i(in.alu_op), .reg_dst_i(in.reg_dst), .mem_to_reg_i(in.mem_to_reg), .branch_i(in.branch),
        .alu_src_i(in.alu_src), .reg_write_i(in.reg_write), .jump_i(in.jump),
        .mem_read_i(in.mem_read), .mem_write_i(in.mem_write),
        .pc_plus4_i(in.pc_plus4), .rs_data_i(in.rs_data), .rt_data_i(in.rt_data), .imm_i(in.imm),
        .rs_i(in.rs), .rt_i(in.rt), .rd_i(in.rd),
        .alu_op_o(alu_op_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .branch_o(branch_o),
        .alu_src_o(alu_src_o), .reg_write_o(reg_write_o), .jump_o(jump_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .pc_plus4_o(pc_plus4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
        .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o),
        .valid_o(valid_o), .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    assign dut_v = {alu_op_o, reg_dst_o, mem_to_reg_o, branch_o, alu_src_o, reg_write_o, jump_o,
                    mem_read_o, mem_write_o, pc_plus4_o, rs_data_o, rt_data_o, imm_o,
                    rs_o, rt_o, rd_o, valid_o};

    function automatic logic hazard(ex_t s, ex_t id);
        return s.valid && s.mem_read && s.rt != 0 && (s.rt == id.rs || s.rt == id.rt);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 1;
    endfunction

    // Model: next EX slot chosen by priority; a bubble is the ID word with controls cleared.
    always @(posedge clk_i) begin
        b = in;
        {b.alu_op, b.reg_dst, b.mem_to_reg, b.branch} = '0;
        {b.alu_src, b.reg_write, b.jump, b.mem_read, b.mem_write, b.valid} = '0;
        l = in;
        l.valid = 1'b1;
        if (rst_i) begin
            m = '0; mbc = 0; mfc = 0;
        end else if (flush_i) begin
            m = b; mfc = sat_inc(mfc);
        end else if (!hold_i) begin
            if (hazard(m, in)) begin
                m = b; mbc = sat_inc(mbc);
            end else
                m = l;
        end
        started = 1'b1;
    end

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    always @(negedge clk_i) if (started) begin
        checks++;
        if (dut_v !== m) begin
            errors++;
            $display("FAIL ex_fields actual=%h expected=%h", dut_v, m);
        end
        check("stall", {31'b0, stall_o}, {31'b0, (hazard(m, in) | hold_i) & ~flush_i});
        check("bubble_cnt", bubble_cnt_o, PC ? mbc : 32'd0);
        check("flush_cnt", flush_cnt_o, PC ? mfc : 32'd0);
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_in;
        in.alu_op = 2'($urandom); in.reg_dst = 2'($urandom); in.mem_to_reg = 2'($urandom);
        in.branch = 2'($urandom); in.alu_src = 1'($urandom); in.reg_write = 1'($urandom);
        in.jump = 1'($urandom); in.mem_read = 1'($urandom); in.mem_write = 1'($urandom);
        in.pc_plus4 = $urandom; in.rs_data = $urandom; in.rt_data = $urandom; in.imm = $urandom;
        in.rs = 5'($urandom_range(0, 3)); in.rt = 5'($urandom_range(0, 3)); in.rd = 5'($urandom);
    endtask

    initial begin
        // T1 reset with random inputs
        rand_in(); flush_i = 1'($urandom);
        tick(); rand_in();
        tick();
        check("t1_valid", {31'b0, valid_o}, 0);
        check("t1_rs_data", rs_data_o, 0);
        check("t1_reg_write", {31'b0, reg_write_o}, 0);
        #1 check("t1_stall", {31'b0, stall_o}, 0);
        rst_i = 1'b0; flush_i = 1'b0;
        // T2 R-type
        in = '0; in.alu_op = 2'b10; in.reg_dst = 2'b01; in.reg_write = 1'b1;
        in.rs_data = 32'h5; in.rt_data = 32'h7; in.rs = 1; in.rt = 2; in.rd = 3;
        tick();
        check("t2_alu_op", {30'b0, alu_op_o}, 2);
        check("t2_reg_dst", {30'b0, reg_dst_o}, 1);
        check("t2_rs_data", rs_data_o, 32'h5);
        check("t2_rt_data", rt_data_o, 32'h7);
        check("t2_valid", {31'b0, valid_o}, 1);
        // T3 load-use
        in = '0; in.mem_read = 1'b1; in.reg_write = 1'b1; in.mem_to_reg = 2'b01; in.alu_src = 1'b1;
        in.rs = 9; in.rt = 8; in.imm = 4;
        tick();
        in = '0; in.alu_op = 2'b10; in.reg_write = 1'b1; in.rs = 8; in.rt = 10; in.rd = 11;
        #1 check("t3_stall_on", {31'b0, stall_o}, 1);
        tick();
        check("t3_bubble_valid", {31'b0, valid_o}, 0);
        check("t3_bubble_rw", {31'b0, reg_write_o}, 0);
        check("t3_bubble_rs", {27'b0, rs_o}, 8);
        #1 check("t3_stall_off", {31'b0, stall_o}, 0);
        tick();
        check("t3_add_valid", {31'b0, valid_o}, 1);
        check("t3_add_rd", {27'b0, rd_o}, 11);
        check("t3_bcnt", bubble_cnt_o, PC ? 32'd1 : 32'd0);
        // T4 $zero never hazards
        in = '0; in.mem_read = 1'b1; in.rs = 3; in.rt = 0;
        tick();
        in = '0; in.reg_write = 1'b1; in.rs = 0; in.rt = 0;
        #1 check("t4_stall", {31'b0, stall_o}, 0);
        tick();
        check("t4_valid", {31'b0, valid_o}, 1);
        // T5 flush beats hazard
        in = '0; in.mem_read = 1'b1; in.rt = 8;
        tick();
        in = '0; in.reg_write = 1'b1; in.rs = 8; flush_i = 1'b1;
        #1 check("t5_stall", {31'b0, stall_o}, 0);
        tick();
        flush_i = 1'b0;
        check("t5_valid", {31'b0, valid_o}, 0);
        check("t5_reg_write", {31'b0, reg_write_o}, 0);
        check("t5_fcnt", flush_cnt_o, PC ? 32'd1 : 32'd0);
        check("t5_bcnt", bubble_cnt_o, PC ? 32'd1 : 32'd0);
        // T6 hold
        in = '0; in.reg_write = 1'b1; in.rs_data = 32'hAA; in.rd = 4;
        tick();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in.rs_data = 32'h100 + i; in.rd = 5'(12 + i); in.jump = 1'b1;
            #1 check("t6_stall", {31'b0, stall_o}, 1);
            tick();
            check("t6_frozen_data", rs_data_o, 32'hAA);
            check("t6_frozen_valid", {31'b0, valid_o}, 1);
        end
        hold_i = 1'b0; in.rs_data = 32'hBB;
        tick();
        check("t6_release", rs_data_o, 32'hBB);
        // random mix checked by the per-cycle model
        for (int i = 0; i < 400; i++) begin
            rand_in();
            flush_i = ($urandom_range(0, 7) == 0);
            hold_i  = ($urandom_range(0, 7) == 0);
            rst_i   = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst_i = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
        tick();
        @(negedge clk_i);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
